// File: rtl/cfg_seq_ctrl.sv
// Command-table driven configuration sequencer: walks a small table of
// write / read-verify / wait / end commands over a single-outstanding cfg bus.
module cfg_seq_ctrl #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int TMO   = 4096
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     tbl_wr_en,
    input  logic [$clog2(DEPTH)-1:0] tbl_wr_addr,
    input  logic [1:0]               tbl_wr_op,
    input  logic                     tbl_wr_type,
    input  logic [AW-1:0]            tbl_wr_addr_f,
    input  logic [DW-1:0]            tbl_wr_data_f,
    input  logic                     start,
    output logic                     cfg_type,
    output logic                     cfg_wr_en,
    output logic [AW-1:0]            cfg_wr_addr,
    output logic [DW-1:0]            cfg_wr_data,
    output logic                     cfg_rd_en,
    output logic [AW-1:0]            cfg_rd_addr,
    input  logic                     cfg_ack,
    input  logic                     cfg_rd_vld,
    input  logic [DW-1:0]            cfg_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH)-1:0] err_idx,
    output logic [1:0]               err_code,
    output logic [DW-1:0]            rd_data_last,
    output logic                     tx_data_en
);
    localparam int IW = $clog2(DEPTH);
    localparam int EW = 3 + AW + DW;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [DW-1:0] LO16_MASK = DW'({16{1'b1}});

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WAIT = 2'd2;
    localparam logic [1:0] OP_END  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_ACK,
        DELAY,
        DONE,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [DW-1:0]   dly_cnt_q, dly_cnt_d;
    logic            cfg_type_q, cfg_type_d;
    logic            cfg_wr_en_q, cfg_wr_en_d;
    logic [AW-1:0]   cfg_wr_addr_q, cfg_wr_addr_d;
    logic [DW-1:0]   cfg_wr_data_q, cfg_wr_data_d;
    logic            cfg_rd_en_q, cfg_rd_en_d;
    logic [AW-1:0]   cfg_rd_addr_q, cfg_rd_addr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [IW-1:0]   err_idx_q, err_idx_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [DW-1:0]   rd_data_last_q, rd_data_last_d;
    logic            tx_data_en_q, tx_data_en_d;

    logic [EW-1:0]   tbl_mem [DEPTH];
    logic [EW-1:0]   ent_q;
    logic [1:0]      ent_op;
    logic            ent_type;
    logic [AW-1:0]   ent_addr;
    logic [DW-1:0]   ent_data;
    logic            step_done;
    logic            rd_bad;

    // Table is not reset so its contents survive rstn; the read is registered
    // and the pointer is stable throughout FETCH, so ent_q is valid in ISSUE.
    always_ff @(posedge clk) begin
        if (tbl_wr_en && !busy)
            tbl_mem[tbl_wr_addr] <= {tbl_wr_op, tbl_wr_type, tbl_wr_addr_f, tbl_wr_data_f};
        ent_q <= tbl_mem[ptr_q];
    end

    assign {ent_op, ent_type, ent_addr, ent_data} = ent_q;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        tmo_cnt_d      = tmo_cnt_q;
        dly_cnt_d      = dly_cnt_q;
        cfg_type_d     = cfg_type_q;
        cfg_wr_en_d    = 1'b0;
        cfg_wr_addr_d  = cfg_wr_addr_q;
        cfg_wr_data_d  = cfg_wr_data_q;
        cfg_rd_en_d    = 1'b0;
        cfg_rd_addr_d  = cfg_rd_addr_q;
        done_d         = done_q;
        err_d          = err_q;
        err_idx_d      = err_idx_q;
        err_code_d     = err_code_q;
        rd_data_last_d = rd_data_last_q;
        tx_data_en_d   = tx_data_en_q;
        step_done      = 1'b0;
        rd_bad         = ent_type ? (cfg_rd_data != ent_data)
                                  : ((cfg_rd_data & LO16_MASK) != (ent_data & LO16_MASK));

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    err_code_d   = 2'd0;
                    tx_data_en_d = 1'b0;
                    ptr_d        = '0;
                    state_d      = FETCH;
                end
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                // Pulses are registered, so they appear in the first WAIT_ACK
                // cycle; an ack during ISSUE is therefore never looked at.
                case (ent_op)
                    OP_WR: begin
                        cfg_wr_en_d   = 1'b1;
                        cfg_type_d    = ent_type;
                        cfg_wr_addr_d = ent_addr;
                        cfg_wr_data_d = ent_type ? ent_data : (ent_data & LO16_MASK);
                        tmo_cnt_d     = '0;
                        state_d       = WAIT_ACK;
                    end
                    OP_RD: begin
                        cfg_rd_en_d   = 1'b1;
                        cfg_type_d    = ent_type;
                        cfg_rd_addr_d = ent_addr;
                        tmo_cnt_d     = '0;
                        state_d       = WAIT_ACK;
                    end
                    OP_WAIT: begin
                        dly_cnt_d = (ent_data == '0) ? '0 : ent_data - DW'(1);
                        state_d   = DELAY;
                    end
                    default: begin
                        done_d       = 1'b1;
                        tx_data_en_d = 1'b1;
                        state_d      = DONE;
                    end
                endcase
            end
            WAIT_ACK: begin
                if (ent_op == OP_WR && cfg_ack) begin
                    step_done = 1'b1;
                end else if (ent_op == OP_RD && cfg_rd_vld) begin
                    rd_data_last_d = cfg_rd_data;
                    if (rd_bad) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        err_idx_d  = ptr_q;
                        state_d    = ERROR;
                    end else begin
                        step_done = 1'b1;
                    end
                end else if (tmo_cnt_q == TW'(TMO - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    err_idx_d  = ptr_q;
                    state_d    = ERROR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            DELAY: begin
                if (dly_cnt_q == '0)
                    step_done = 1'b1;
                else
                    dly_cnt_d = dly_cnt_q - DW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Running off the end of the table finishes without wrapping.
        if (step_done) begin
            if (ptr_q == IW'(DEPTH - 1)) begin
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                ptr_d   = ptr_q + IW'(1);
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            tmo_cnt_q      <= '0;
            dly_cnt_q      <= '0;
            cfg_type_q     <= 1'b0;
            cfg_wr_en_q    <= 1'b0;
            cfg_wr_addr_q  <= '0;
            cfg_wr_data_q  <= '0;
            cfg_rd_en_q    <= 1'b0;
            cfg_rd_addr_q  <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_idx_q      <= '0;
            err_code_q     <= 2'd0;
            rd_data_last_q <= '0;
            tx_data_en_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            tmo_cnt_q      <= tmo_cnt_d;
            dly_cnt_q      <= dly_cnt_d;
            cfg_type_q     <= cfg_type_d;
            cfg_wr_en_q    <= cfg_wr_en_d;
            cfg_wr_addr_q  <= cfg_wr_addr_d;
            cfg_wr_data_q  <= cfg_wr_data_d;
            cfg_rd_en_q    <= cfg_rd_en_d;
            cfg_rd_addr_q  <= cfg_rd_addr_d;
            done_q         <= done_d;
            err_q          <= err_d;
            err_idx_q      <= err_idx_d;
            err_code_q     <= err_code_d;
            rd_data_last_q <= rd_data_last_d;
            tx_data_en_q   <= tx_data_en_d;
        end
    end

    assign busy         = (state_q == FETCH) || (state_q == ISSUE) ||
                          (state_q == WAIT_ACK) || (state_q == DELAY);
    assign cfg_type     = cfg_type_q;
    assign cfg_wr_en    = cfg_wr_en_q;
    assign cfg_wr_addr  = cfg_wr_addr_q;
    assign cfg_wr_data  = cfg_wr_data_q;
    assign cfg_rd_en    = cfg_rd_en_q;
    assign cfg_rd_addr  = cfg_rd_addr_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_idx      = err_idx_q;
    assign err_code     = err_code_q;
    assign rd_data_last = rd_data_last_q;
    assign tx_data_en   = tx_data_en_q;

endmodule
